// File: rtl/keypad_pkg.sv
// Shared types and constants for the hex keypad scanner and its entry register.
package keypad_pkg;

    typedef enum logic [1:0] {IDLE, CAND, PRESSED, REL} kp_state_t;
    typedef enum logic [1:0] {NONE, ONE, MULTI} scan_res_t;

    localparam logic [3:0]  KEY_ENTER  = 4'hE;
    localparam logic [3:0]  KEY_CLEAR  = 4'hF;
    localparam int unsigned NUM_DIGITS = 4;

    function automatic logic [2:0] count_hits(input logic [3:0] hits);
        count_hits = 3'(hits[0]) + 3'(hits[1]) + 3'(hits[2]) + 3'(hits[3]);
    endfunction

endpackage

// File: rtl/keypad_entry_reg.sv
// Digit entry register: shifts confirmed digits in, ENTER requests a load, CLEAR empties.
module keypad_entry_reg
    import keypad_pkg::*;
(
    input  logic        clk100Hz,
    input  logic        reset,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    output logic [15:0] digits,
    output logic [2:0]  entry_count,
    output logic        load_pulse
);

    always_ff @(posedge clk100Hz) begin
        if (reset) begin
            digits      <= '0;
            entry_count <= '0;
            load_pulse  <= 1'b0;
        end else begin
            load_pulse <= 1'b0;
            if (key_valid) begin
                if (key_code == KEY_CLEAR) begin
                    digits      <= '0;
                    entry_count <= '0;
                end else if (key_code == KEY_ENTER) begin
                    // ENTER only acts on a complete entry; otherwise it is ignored
                    if (entry_count == 3'(NUM_DIGITS))
                        load_pulse <= 1'b1;
                end else begin
                    digits <= {digits[11:0], key_code};
                    if (entry_count != 3'(NUM_DIGITS))
                        entry_count <= entry_count + 3'd1;
                end
            end
        end
    end

endmodule

// File: rtl/hex_keypad_scanner.sv
// 4x4 active-low keypad scanner: row synchronizer, column scan, per-scan classifier,
// debounce FSM with registered strobe/held/code, and the digit entry register.
module hex_keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned DWELL    = 3,
    parameter int unsigned DEBOUNCE = 2
) (
    input  logic        clk100Hz,
    input  logic        reset,
    input  logic [3:0]  row_n,
    output logic [3:0]  col_n,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic        key_held,
    output logic [15:0] digits,
    output logic [2:0]  entry_count,
    output logic        load_pulse
);

    localparam int unsigned DW_W  = $clog2(DWELL);
    localparam int unsigned CNT_W = $clog2(DEBOUNCE + 1);

    logic [3:0]       row_meta;
    logic [3:0]       row_sync;
    logic [1:0]       col_idx;
    logic [DW_W-1:0]  dwell;
    logic [1:0]       acc_hits;
    logic [3:0]       acc_code;

    kp_state_t        state;
    logic [3:0]       cand;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    logic             sample;
    logic             scan_done;
    logic [3:0]       cur_hit;
    logic [2:0]       cur_n;
    logic [1:0]       cur_row;
    logic [2:0]       tot_raw;
    logic [3:0]       scan_code;
    scan_res_t        scan_res;

    assign col_n = ~(4'b0001 << col_idx);

    always_comb begin
        sample    = (dwell == DW_W'(DWELL - 1));
        scan_done = sample && (col_idx == 2'd3);
        cur_hit   = ~row_sync;
        cur_n     = count_hits(cur_hit);
        cur_row   = 2'd0;
        for (int unsigned r = 4; r > 0; r--) begin
            if (cur_hit[r-1])
                cur_row = 2'(r - 1);
        end
        tot_raw   = {1'b0, acc_hits} + cur_n;
        // An earlier column's single hit keeps its code; it only matters if the total stays at one
        scan_code = (acc_hits != 2'd0) ? acc_code : {cur_row, col_idx};
        if (tot_raw == 3'd0)
            scan_res = NONE;
        else if (tot_raw == 3'd1)
            scan_res = ONE;
        else
            scan_res = MULTI;
        cnt_next  = cnt + CNT_W'(1);
    end

    always_ff @(posedge clk100Hz) begin
        if (reset) begin
            row_meta <= '1;
            row_sync <= '1;
            col_idx  <= '0;
            dwell    <= '0;
            acc_hits <= '0;
            acc_code <= '0;
        end else begin
            row_meta <= row_n;
            row_sync <= row_meta;
            if (sample) begin
                dwell   <= '0;
                col_idx <= col_idx + 2'd1;
                if (col_idx == 2'd3) begin
                    acc_hits <= '0;
                    acc_code <= '0;
                end else begin
                    acc_hits <= (tot_raw >= 3'd2) ? 2'd2 : tot_raw[1:0];
                    acc_code <= scan_code;
                end
            end else begin
                dwell <= dwell + DW_W'(1);
            end
        end
    end

    always_ff @(posedge clk100Hz) begin
        if (reset) begin
            state     <= IDLE;
            cand      <= '0;
            cnt       <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (scan_done) begin
                case (state)
                    IDLE: begin
                        if (scan_res == ONE) begin
                            if (DEBOUNCE == 1) begin
                                state     <= PRESSED;
                                key_code  <= scan_code;
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                            end else begin
                                state <= CAND;
                                cand  <= scan_code;
                                cnt   <= CNT_W'(1);
                            end
                        end
                    end
                    CAND: begin
                        if (scan_res == ONE && scan_code == cand) begin
                            cnt <= cnt_next;
                            if (cnt_next == CNT_W'(DEBOUNCE)) begin
                                state     <= PRESSED;
                                key_code  <= cand;
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                            end
                        end else if (scan_res == ONE) begin
                            cand <= scan_code;
                            cnt  <= CNT_W'(1);
                        end else begin
                            state <= IDLE;
                        end
                    end
                    PRESSED: begin
                        if (scan_res == NONE) begin
                            if (DEBOUNCE == 1) begin
                                state    <= IDLE;
                                key_held <= 1'b0;
                            end else begin
                                state <= REL;
                                cnt   <= CNT_W'(1);
                            end
                        end
                    end
                    REL: begin
                        if (scan_res == NONE) begin
                            cnt <= cnt_next;
                            if (cnt_next == CNT_W'(DEBOUNCE)) begin
                                state    <= IDLE;
                                key_held <= 1'b0;
                            end
                        end else begin
                            state <= PRESSED;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    keypad_entry_reg u_entry (
        .clk100Hz    (clk100Hz),
        .reset       (reset),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .digits      (digits),
        .entry_count (entry_count),
        .load_pulse  (load_pulse)
    );

endmodule
